// File: rtl/pcs_rx_align_sync_if.sv
// Receive-path bus between the deserialiser, pcs_rx_align_sync and the 8b/10b decoder.
// PCS_SYNC_STATS_EN adds the sync_loss_cnt statistics signal.
interface pcs_rx_align_sync_if;
    logic        signal_detect;
    logic [9:0]  rx_raw;
    logic [9:0]  cg_out;
    logic        code_sync_status;
    logic        rx_even;
    logic        cg_invalid;
    logic [3:0]  comma_pos;
    logic        rd_pos;
`ifdef PCS_SYNC_STATS_EN
    logic [15:0] sync_loss_cnt;

    modport master (
        output signal_detect, rx_raw,
        input  cg_out, code_sync_status, rx_even, cg_invalid, comma_pos, rd_pos, sync_loss_cnt
    );
    modport slave (
        input  signal_detect, rx_raw,
        output cg_out, code_sync_status, rx_even, cg_invalid, comma_pos, rd_pos, sync_loss_cnt
    );
`else
    modport master (
        output signal_detect, rx_raw,
        input  cg_out, code_sync_status, rx_even, cg_invalid, comma_pos, rd_pos
    );
    modport slave (
        input  signal_detect, rx_raw,
        output cg_out, code_sync_status, rx_even, cg_invalid, comma_pos, rd_pos
    );
`endif
endinterface

// File: rtl/pcs_rx_align_sync.sv
// Comma-aligning 1000BASE-X receive front end with a Clause-36-style sync FSM.
// Define PCS_SYNC_STATS_EN to add the saturating sync_loss_cnt statistic.
module pcs_rx_align_sync #(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_CNT   = 4,
    parameter int GOOD_CGS   = 3
) (
    input logic                clk,
    input logic                reset,
    pcs_rx_align_sync_if.slave bus
);

    typedef enum logic [1:0] {
        LOS,
        CD,
        SYNC
    } sync_state_t;

    sync_state_t state;
    logic [9:0]  r0, r1;
    logic [9:0]  cg_q;
    logic        sync_q, even_q, invalid_q, rd_q;
    logic [3:0]  pos_q;
    logic [2:0]  comma_cnt, bad_cnt, good_cnt;

    logic [19:0] win;
    logic        found;
    logic [3:0]  k_found, k_use;
    logic [9:0]  cg;
    logic [3:0]  ones;
    logic        is_comma, in_sync, invalid, rd_nx, even_nx, bad_cg;

    function automatic logic [9:0] slot(input logic [19:0] w, input logic [3:0] k);
        logic [19:0] s;
        s = w << k;
        return s[19:10];
    endfunction

    function automatic logic comma_match(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    assign win     = {r1, r0};
    assign in_sync = (state == SYNC);

    // Lowest offset wins, so the search runs downward and keeps the last hit.
    always_comb begin
        found   = 1'b0;
        k_found = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (comma_match(slot(win, 4'(k)))) begin
                found   = 1'b1;
                k_found = 4'(k);
            end
        end
    end

    assign k_use    = (!in_sync && found) ? k_found : pos_q;
    assign cg       = slot(win, k_use);
    assign ones     = 4'($countones(cg));
    assign is_comma = comma_match(cg);

    // Outside SYNC a comma re-seeds disparity and even parity instead of being checked.
    always_comb begin
        invalid = 1'b0;
        rd_nx   = rd_q;
        even_nx = ~even_q;
        if (!in_sync && is_comma) begin
            invalid = (ones < 4'd4) || (ones > 4'd6);
            rd_nx   = (ones == 4'd6);
            even_nx = 1'b1;
        end else begin
            case (ones)
                4'd5: invalid = 1'b0;
                4'd6: begin
                    invalid = rd_q;
                    rd_nx   = 1'b1;
                end
                4'd4: begin
                    invalid = ~rd_q;
                    rd_nx   = 1'b0;
                end
                default: begin
                    invalid = 1'b1;
                    rd_nx   = (ones > 4'd5);
                end
            endcase
        end
        bad_cg = invalid || (is_comma && even_q);
    end

    // Status outputs are registered alongside the code-group they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0        <= '0;
            r1        <= '0;
            cg_q      <= '0;
            pos_q     <= '0;
            even_q    <= 1'b0;
            invalid_q <= 1'b0;
            rd_q      <= 1'b0;
            sync_q    <= 1'b0;
            state     <= LOS;
            comma_cnt <= '0;
            bad_cnt   <= '0;
            good_cnt  <= '0;
        end else begin
            r0        <= bus.rx_raw;
            r1        <= r0;
            cg_q      <= cg;
            pos_q     <= k_use;
            even_q    <= even_nx;
            invalid_q <= invalid;
            rd_q      <= rd_nx;
            case (state)
                LOS: begin
                    if (is_comma && !invalid) begin
                        comma_cnt <= 3'd1;
                        if (ACQ_COMMAS <= 1) begin
                            state    <= SYNC;
                            sync_q   <= 1'b1;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                        end else begin
                            state <= CD;
                        end
                    end
                end
                CD: begin
                    if (bad_cg) begin
                        state     <= LOS;
                        comma_cnt <= '0;
                    end else if (is_comma) begin
                        comma_cnt <= comma_cnt + 3'd1;
                        if (comma_cnt + 3'd1 == 3'(ACQ_COMMAS)) begin
                            state    <= SYNC;
                            sync_q   <= 1'b1;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                        end
                    end
                end
                SYNC: begin
                    if (bad_cg) begin
                        bad_cnt  <= bad_cnt + 3'd1;
                        good_cnt <= '0;
                        if (bad_cnt + 3'd1 == 3'(LOSS_CNT)) begin
                            state     <= LOS;
                            sync_q    <= 1'b0;
                            bad_cnt   <= '0;
                            comma_cnt <= '0;
                        end
                    end else if (bad_cnt != 3'd0) begin
                        if (good_cnt + 3'd1 == 3'(GOOD_CGS)) begin
                            bad_cnt  <= bad_cnt - 3'd1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state  <= LOS;
                    sync_q <= 1'b0;
                end
            endcase
            if (!bus.signal_detect) begin
                state     <= LOS;
                sync_q    <= 1'b0;
                comma_cnt <= '0;
                bad_cnt   <= '0;
                good_cnt  <= '0;
            end
        end
    end

`ifdef PCS_SYNC_STATS_EN
    logic [15:0] loss_q;
    logic        loss_event;

    assign loss_event = in_sync &&
                        (!bus.signal_detect || (bad_cg && (bad_cnt + 3'd1 == 3'(LOSS_CNT))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (loss_event && loss_q != 16'hFFFF) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign bus.sync_loss_cnt = loss_q;
`endif

    assign bus.cg_out           = cg_q;
    assign bus.code_sync_status = sync_q;
    assign bus.rx_even          = even_q;
    assign bus.cg_invalid       = invalid_q;
    assign bus.comma_pos        = pos_q;
    assign bus.rd_pos           = rd_q;

endmodule
